// File: rtl/combination_sender.sv
// rtl/combination_sender.sv - plays a latched combination as zero/one pulses and grades the lock response
module combination_sender #(
  parameter int CODE_LEN   = 5,
  parameter int GAP_CYCLES = 1,
  parameter int CHECK_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code_in,
  input  logic                unlocked_in,
  output logic                zero,
  output logic                one,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [2:0]          state,
  output logic [3:0]          sym_idx
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WW = (CHECK_WAIT > 1) ? $clog2(CHECK_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_GAP   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_n;
  logic [CODE_LEN-1:0] shreg_q, shreg_n;
  logic [3:0]          sym_q, sym_n;
  logic [GW-1:0]       gap_q, gap_n;
  logic [WW-1:0]       wait_q, wait_n;
  logic                zero_n, one_n, done_n, pass_n, fail_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      sym_q   <= '0;
      gap_q   <= '0;
      wait_q  <= '0;
      zero    <= 1'b0;
      one     <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_n;
      shreg_q <= shreg_n;
      sym_q   <= sym_n;
      gap_q   <= gap_n;
      wait_q  <= wait_n;
      zero    <= zero_n;
      one     <= one_n;
      done    <= done_n;
      pass    <= pass_n;
      fail    <= fail_n;
    end
  end

  // Pulses are computed on the way into SEND so they appear registered in the SEND cycle itself.
  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    sym_n   = sym_q;
    gap_n   = gap_q;
    wait_n  = wait_q;
    zero_n  = 1'b0;
    one_n   = 1'b0;
    done_n  = 1'b0;
    pass_n  = pass;
    fail_n  = fail;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_n = code_in;
          sym_n   = '0;
          pass_n  = 1'b0;
          fail_n  = 1'b0;
          zero_n  = ~code_in[CODE_LEN-1];
          one_n   = code_in[CODE_LEN-1];
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        gap_n   = '0;
        state_n = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (sym_q == 4'(CODE_LEN - 1)) begin
            wait_n  = '0;
            state_n = S_CHECK;
          end else begin
            shreg_n = shreg_q << 1;
            sym_n   = sym_q + 4'd1;
            zero_n  = ~shreg_q[CODE_LEN-2];
            one_n   = shreg_q[CODE_LEN-2];
            state_n = S_SEND;
          end
        end else begin
          gap_n = gap_q + GW'(1);
        end
      end
      S_CHECK: begin
        if (unlocked_in) begin
          pass_n  = 1'b1;
          done_n  = 1'b1;
          state_n = S_DONE;
        end else if (wait_q == WW'(CHECK_WAIT - 1)) begin
          fail_n  = 1'b1;
          done_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          wait_n = wait_q + WW'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign state   = state_q;
  assign sym_idx = sym_q;

endmodule

// File: tb/tb_combination_sender.sv
// tb/tb_combination_sender.sv - randomized self-checking bench for combination_sender
module tb_combination_sender;

  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] code_in = '0;
  logic       unlocked_in = 1'b0;
  logic       sel = 1'b0;

  logic       zero1, one1, busy1, done1, pass1, fail1;
  logic [2:0] state1;
  logic [3:0] sym1;
  logic       zero2, one2, busy2, done2, pass2, fail2;
  logic [2:0] state2;
  logic [3:0] sym2;
  logic       start1, start2;

  int vectors = 0;
  int miscompares = 0;

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  always #5 clk = ~clk;

  combination_sender #(.CODE_LEN(5), .GAP_CYCLES(1), .CHECK_WAIT(CW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .code_in(code_in), .unlocked_in(unlocked_in),
    .zero(zero1), .one(one1), .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
    .state(state1), .sym_idx(sym1)
  );

  combination_sender #(.CODE_LEN(3), .GAP_CYCLES(3), .CHECK_WAIT(CW)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .code_in(code_in[2:0]), .unlocked_in(unlocked_in),
    .zero(zero2), .one(one2), .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
    .state(state2), .sym_idx(sym2)
  );

  // {zero, one, busy, done, pass, fail, state}
  logic [8:0] obs;
  logic [3:0] obs_sym;
  assign obs     = sel ? {zero2, one2, busy2, done2, pass2, fail2, state2}
                       : {zero1, one1, busy1, done1, pass1, fail1, state1};
  assign obs_sym = sel ? sym2 : sym1;

  // Plays one start on the selected DUT; unlock is a window [lo,hi] of cycles after the start edge.
  task automatic run_seq(input bit s, input logic [4:0] code, input int lo, input int hi,
                         input bit hold, input logic [4:0] alt, input int stop_at);
    int L, P, cs, d, first, i;
    bit pf, pulse, b;
    logic [8:0] e;
    L = s ? 3 : 5;
    P = s ? 4 : 2;
    cs = L * P + 1;
    first = 0;
    for (int c = cs; c < cs + CW; c++)
      if (first == 0 && c >= lo && c <= hi) first = c;
    pf = (first != 0);
    d = pf ? first + 1 : cs + CW;
    sel = s;
    code_in = code;
    unlocked_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= d + 2; c++) begin
      unlocked_in = (c >= lo && c <= hi);
      if (hold && c == 3) code_in = alt;
      if (c == stop_at) begin
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 9'd0 || obs_sym !== 4'd0) begin
          $display("FAIL async_reset c=%0d got %b/%0d exp 0/0", c, obs, obs_sym);
          miscompares++;
        end
        rst = 1'b0;
        break;
      end
      i = (c - 1) / P;
      pulse = (c < cs) && ((c - 1) % P == 0);
      b = code[L-1-i];
      e[8] = pulse && !b;
      e[7] = pulse && b;
      e[6] = (c <= d);
      e[5] = (c == d);
      e[4] = (c >= d) && pf;
      e[3] = (c >= d) && !pf;
      e[2:0] = (c > d) ? 3'd0 : (c == d) ? 3'd4 : (c >= cs) ? 3'd3 : pulse ? 3'd1 : 3'd2;
      if (hold && c == d + 2) begin
        e = {~alt[L-1], alt[L-1], 1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
        i = 0;
      end
      vectors++;
      if (obs !== e) begin
        $display("FAIL outputs s=%0d code=%b c=%0d got %b exp %b", s, code, c, obs, e);
        miscompares++;
      end
      if (c < cs || (hold && c == d + 2)) begin
        vectors++;
        if (obs_sym !== 4'(i)) begin
          $display("FAIL sym_idx s=%0d c=%0d got %0d exp %0d", s, c, obs_sym, i);
          miscompares++;
        end
      end
      vectors++;
      if (obs[8] && obs[7]) begin
        $display("FAIL exclusive s=%0d c=%0d got zero=1 one=1 exp not both", s, c);
        miscompares++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    unlocked_in = 1'b0;
    if (hold) begin
      rst = 1'b1;
      #1 rst = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      vectors++;
      if (obs !== 9'd0 || obs_sym !== 4'd0) begin
        $display("FAIL reset_state dut=%0d got %b/%0d exp 0/0", k, obs, obs_sym);
        miscompares++;
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run_seq(1'b0, 5'b01011, 0, 0, 1'b0, 5'd0, 0);
    run_seq(1'b0, 5'b01011, 11, 999, 1'b0, 5'd0, 0);
    run_seq(1'b0, 5'b01111, 0, 0, 1'b0, 5'd0, 0);
    run_seq(1'b0, 5'b10100, 14, 14, 1'b0, 5'd0, 0);
    run_seq(1'b0, 5'b11000, 3, 9, 1'b0, 5'd0, 0);
  endtask

  task automatic test_mid_reset;
    run_seq(1'b0, 5'b01011, 0, 0, 1'b0, 5'd0, 6);
    run_seq(1'b0, 5'b01011, 12, 999, 1'b0, 5'd0, 0);
  endtask

  task automatic test_back_to_back;
    run_seq(1'b0, 5'b10110, 0, 0, 1'b1, 5'b01001, 0);
    run_seq(1'b0, 5'b00111, 13, 999, 1'b1, 5'b11100, 0);
  endtask

  task automatic test_gap3;
    run_seq(1'b1, 5'b00101, 0, 0, 1'b0, 5'd0, 0);
    run_seq(1'b1, 5'b00101, 16, 16, 1'b0, 5'd0, 0);
  endtask

  task automatic test_random;
    bit s;
    int cs, lo, hi;
    for (int n = 0; n < 12; n++) begin
      s = 1'($urandom_range(0, 1));
      cs = s ? 13 : 11;
      lo = $urandom_range(cs - 3, cs + CW + 1);
      hi = lo + $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        lo = 0;
        hi = 0;
      end
      run_seq(s, 5'($urandom), lo, hi, 1'b0, 5'd0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_reset();
    test_back_to_back();
    test_gap3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
